ram_rr_arbiter: RTL and testbench
=================================

Name: ram_rr_arbiter

Overview:
Round-robin arbiter sharing one single_port_RAM instance between NREQ requesters. Each requester gets a valid/ready request channel and a read-response channel. At most one access is granted per cycle and driven straight into the RAM. Read data returns one cycle after acceptance, tagged to the requester that issued it.

Parameters:
DEPTH, 8, RAM depth in words; passed to single_port_RAM
WIDTH, 8, data width in bits; passed to single_port_RAM
NREQ, 2, number of requesters; must be at least 2
AW, $clog2(DEPTH), derived localparam: address width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_we  in  NREQ  per-requester write enable (1 = write, 0 = read)
req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
req_wdata  in  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
rsp_valid  out  NREQ  one-hot read-response strobe
rsp_rdata  out  WIDTH  read data, shared by all requesters; qualified by rsp_valid only

Behaviour:
- Reset: rst_n low asynchronously clears the priority pointer ptr to 0 and rsp_valid to 0.
  - req_ready is forced to 0 while rst_n is low.
  - RAM contents are not reset.
- Grant is combinational. Starting at index ptr and wrapping modulo NREQ, the first i with req_valid[i]=1 gets grant[i]=1.
- req_ready = grant. A request is accepted in any cycle where req_valid[i] and req_ready[i] are both 1.
- A requester must hold valid, we, addr and wdata stable until accepted. The arbiter does not check this.
- RAM drive, same cycle as acceptance:
  - addr = granted requester's address; data_in = granted requester's wdata.
  - w_en = grant-any AND granted requester's req_we.
  - With no grant: addr = 0, w_en = 0, data_in = 0.
- Pointer update on every accept: ptr <= granted index + 1, wrapping to 0 after NREQ-1. With no accept, ptr holds.
  - Guarantee: a held request waits at most NREQ-1 cycles.
- Read response:
  - On an accepted read, rsp_valid <= one-hot of the granted index at the next edge. Otherwise rsp_valid <= 0.
  - Latency is exactly 1 cycle: rsp_rdata = RAM data_out in the cycle rsp_valid is high.
  - Accepted writes produce no response.
  - Reads may issue back-to-back, one per cycle.
- rsp_rdata is undefined when rsp_valid = 0, including after reset before the first access.
- Read of a location written in the same cycle: impossible, since only one access is granted per cycle.
- Write at cycle N followed by read at N+1 of the same address returns the new data.
- Reset mid-operation: a response pending from the cycle before reset is dropped (rsp_valid stays 0). A write accepted before reset remains in the RAM.
- Addresses wrap naturally within AW bits. Out-of-range addresses when DEPTH is not a power of 2 are not protected against.

Decomposition:
- Package ram_arb_pkg holds:
  - default NREQ, DEPTH and WIDTH constants;
  - a function computing next_ptr(idx, NREQ).
- Sub-module: single_port_RAM, the existing block, instantiated unchanged.
- The arbiter logic (grant search, mux, response register) lives in ram_rr_arbiter itself.

Test Plan:
- Reset: rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0. After release, the first grant goes to requester 0.
- Write then read, requester 0:
  - Stimulus: write addr 3 data 0xA5; next cycle read addr 3.
  - Response: rsp_valid=2'b01 on the following cycle with rsp_rdata=0xA5; no rsp_valid for the write.
- Contention, both requesters holding reads of addr 1 / addr 2 (preloaded 0x11 / 0x22) for 4 cycles:
  - Grants go 0,1,0,1.
  - rsp_valid goes 01,10,01,10 with rdata 0x11,0x22,0x11,0x22, each one cycle behind its grant.
- Fairness: requester 1 holds a write while requester 0 issues continuous reads -> requester 1 is accepted within 1 cycle of asserting valid.
- Reset mid-flight: read of addr 5 accepted at cycle N, rst_n low during cycle N+1 -> rsp_valid never asserts, ptr=0 afterwards. A prior write to addr 5 reads back intact after reset.
- Boundary address: write addr 7 data 0xFF, then read addr 7 -> 0xFF. Addr 0 is unaffected (reads its earlier value 0x00 after a preload write).

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared defaults and helpers for the round-robin RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned DefNreq  = 2;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefWidth = 8;

  // Priority pointer after serving requester idx, wrapping at nreq.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/single_port_RAM.sv
// Single-port synchronous RAM: one access per cycle, read data registered one cycle later.
module single_port_RAM #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     w_en,
  output logic [WIDTH-1:0]         data_out
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[addr] <= data_in;
    end
    data_out <= mem[addr];
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NREQ requesters; one access per
// cycle, read data returned one cycle after acceptance with a one-hot requester tag.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NREQ  = DefNreq,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [NREQ-1:0]  valid_m;
  logic [NREQ-1:0]  grant;
  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [PW:0]      cand;
  logic [PW-1:0]    ptr_d, ptr_q;
  logic [NREQ-1:0]  rsp_valid_d, rsp_valid_q;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_we;

  // Search from ptr upward, wrapping; masking with rst_n keeps the RAM idle during reset.
  always_comb begin
    valid_m = req_valid & {NREQ{rst_n}};
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!gnt_any && valid_m[cand[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
    grant = '0;
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        ram_addr  = req_addr[i*AW +: AW];
        ram_wdata = req_wdata[i*WIDTH +: WIDTH];
        ram_we    = req_we[i];
      end
    end
  end

  always_comb begin
    ptr_d       = gnt_any ? PW'(next_ptr(32'(gnt_idx), NREQ)) : ptr_q;
    rsp_valid_d = (gnt_any && !ram_we) ? grant : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  single_port_RAM #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk      (clk),
    .addr     (ram_addr),
    .data_in  (ram_wdata),
    .w_en     (ram_we),
    .data_out (rsp_rdata)
  );

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter: directed scenarios plus randomized traffic against a
// behavioural model (memory array, round-robin pointer, one-cycle response slot).
module tb_ram_rr_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_wdata = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_rdata;

  always #5 clk = ~clk;

  ram_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Requester-side intent.
  logic             t_v  [NREQ];
  logic             t_we [NREQ];
  logic [AW-1:0]    t_a  [NREQ];
  logic [WIDTH-1:0] t_d  [NREQ];

  // Reference model.
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_ptr = 0;
  logic [NREQ-1:0]  m_rsp_v = '0;
  logic [WIDTH-1:0] m_rsp_d = '0;

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                 = t_v[i];
      req_we[i]                    = t_we[i];
      req_addr[i*AW +: AW]         = t_a[i];
      req_wdata[i*WIDTH +: WIDTH]  = t_d[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      t_v[i] = 1'b0; t_we[i] = 1'b0; t_a[i] = '0; t_d[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic we, input int a, input int d);
    t_v[i] = 1'b1; t_we[i] = we; t_a[i] = AW'(a); t_d[i] = WIDTH'(d);
  endtask

  function automatic int m_winner();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (t_v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_grant();
    logic [NREQ-1:0] g;
    int w;
    g = '0;
    w = m_winner();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic m_commit(output int acc);
    acc = m_winner();
    m_rsp_v = '0;
    if (acc >= 0) begin
      if (t_we[acc]) begin
        m_mem[t_a[acc]] = t_d[acc];
      end else begin
        m_rsp_v[acc] = 1'b1;
        m_rsp_d = m_mem[t_a[acc]];
      end
      m_ptr = (acc + 1) % NREQ;
    end
    cyc++;
  endtask

  task automatic m_reset();
    m_ptr = 0;
    m_rsp_v = '0;
  endtask

  task automatic test_reset();
    int acc;
    logic [NREQ-1:0] eg;
    clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 0, 0);
    apply();
    #2 rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00) begin
      bad++; $display("FAIL rst_ready: got %b want 00", req_ready);
    end
    total++;
    if (rsp_valid !== 2'b00) begin
      bad++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply();
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL first_grant: got %b want 01", req_ready);
    end
    // Drain both writes, then preload the whole RAM so every later read has a known value.
    for (int n = 0; n < 2 + DEPTH; n++) begin
      if (n >= 2) begin
        clear_reqs();
        set_req(0, 1'b1, n - 2, (n == 2) ? 0 : $urandom_range(255, 0));
        apply();
        @(negedge clk);
      end
      eg = m_grant();
      total++;
      if (req_ready !== eg) begin
        bad++; $display("FAIL rst_preload_ready cyc %0d: got %b want %b", cyc, req_ready, eg);
      end
      total++;
      if (rsp_valid !== m_rsp_v) begin
        bad++; $display("FAIL rst_preload_rsp cyc %0d: got %b want %b", cyc, rsp_valid, m_rsp_v);
      end
      @(posedge clk);
      m_commit(acc);
      if (acc >= 0) t_v[acc] = 1'b0;
      #1;
      apply();
    end
  endtask

  task automatic test_write_read();
    int acc;
    logic [NREQ-1:0] eg;
    for (int n = 0; n < 3; n++) begin
      clear_reqs();
      if (n == 0) set_req(0, 1'b1, 3, 'hA5);
      if (n == 1) set_req(0, 1'b0, 3, 0);
      apply();
      @(negedge clk);
      eg = m_grant();
      total++;
      if (req_ready !== eg) begin
        bad++; $display("FAIL wr_rd_ready n=%0d: got %b want %b", n, req_ready, eg);
      end
      total++;
      if (rsp_valid !== m_rsp_v) begin
        bad++; $display("FAIL wr_rd_rsp_valid n=%0d: got %b want %b", n, rsp_valid, m_rsp_v);
      end
      if (m_rsp_v != 0) begin
        total++;
        if (rsp_rdata !== 8'hA5) begin
          bad++; $display("FAIL wr_rd_rdata: got %h want a5", rsp_rdata);
        end
      end
      @(posedge clk);
      m_commit(acc);
      #1;
    end
  endtask

  task automatic test_contention();
    int acc;
    logic [NREQ-1:0] exp_g [4];
    logic [NREQ-1:0] eg;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    // Preload: req0 writes addr1, then req1 writes addr2, leaving the pointer at 0.
    for (int n = 0; n < 2; n++) begin
      clear_reqs();
      set_req(n, 1'b1, n + 1, (n == 0) ? 'h11 : 'h22);
      apply();
      @(posedge clk);
      m_commit(acc);
      #1;
    end
    clear_reqs();
    set_req(0, 1'b0, 1, 0);
    set_req(1, 1'b0, 2, 0);
    for (int n = 0; n < 5; n++) begin
      if (n == 4) clear_reqs();
      apply();
      @(negedge clk);
      eg = m_grant();
      if (n < 4) begin
        total++;
        if (req_ready !== exp_g[n]) begin
          bad++; $display("FAIL cont_grant n=%0d: got %b want %b", n, req_ready, exp_g[n]);
        end
      end
      total++;
      if (req_ready !== eg) begin
        bad++; $display("FAIL cont_ready_model n=%0d: got %b want %b", n, req_ready, eg);
      end
      if (n > 0) begin
        total++;
        if (rsp_valid !== exp_g[n-1]) begin
          bad++; $display("FAIL cont_rsp_valid n=%0d: got %b want %b", n, rsp_valid, exp_g[n-1]);
        end
        total++;
        if (rsp_rdata !== ((exp_g[n-1] == 2'b01) ? 8'h11 : 8'h22)) begin
          bad++; $display("FAIL cont_rdata n=%0d: got %h want %h", n, rsp_rdata,
                          (exp_g[n-1] == 2'b01) ? 8'h11 : 8'h22);
        end
      end
      @(posedge clk);
      m_commit(acc);
      #1;
    end
  endtask

  task automatic test_fairness();
    int acc;
    int wait_cyc;
    bit done;
    clear_reqs();
    set_req(0, 1'b0, 1, 0);
    for (int n = 0; n < 3; n++) begin
      apply();
      @(posedge clk);
      m_commit(acc);
      #1;
    end
    set_req(1, 1'b1, 6, 'h66);
    wait_cyc = 0;
    done = 0;
    for (int n = 0; n < 8 && !done; n++) begin
      apply();
      @(negedge clk);
      total++;
      if (rsp_valid !== m_rsp_v) begin
        bad++; $display("FAIL fair_rsp_valid n=%0d: got %b want %b", n, rsp_valid, m_rsp_v);
      end
      if (req_ready[1] === 1'b1) done = 1;
      else wait_cyc++;
      @(posedge clk);
      m_commit(acc);
      if (acc == 1) t_v[1] = 1'b0;
      #1;
    end
    total++;
    if (!done || wait_cyc > NREQ - 1) begin
      bad++; $display("FAIL fair_wait: got done=%0d wait=%0d want wait<=%0d", done, wait_cyc,
                      NREQ - 1);
    end
    clear_reqs();
    apply();
    @(posedge clk);
    m_commit(acc);
    #1;
  endtask

  task automatic test_reset_midflight();
    int acc;
    logic [NREQ-1:0] eg;
    for (int n = 0; n < 2; n++) begin
      clear_reqs();
      set_req(0, (n == 0), 5, 'h5A);
      apply();
      @(posedge clk);
      m_commit(acc);
      #1;
    end
    rst_n = 1'b0;
    m_reset();
    clear_reqs();
    apply();
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00) begin
        bad++; $display("FAIL midrst_drop n=%0d: got %b want 00", n, rsp_valid);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    set_req(0, 1'b0, 5, 0);
    set_req(1, 1'b0, 5, 0);
    for (int n = 0; n < 3; n++) begin
      apply();
      @(negedge clk);
      eg = m_grant();
      if (n == 0) begin
        total++;
        if (req_ready !== 2'b01) begin
          bad++; $display("FAIL midrst_ptr: got %b want 01", req_ready);
        end
      end
      total++;
      if (rsp_valid !== m_rsp_v) begin
        bad++; $display("FAIL midrst_rsp n=%0d: got %b want %b", n, rsp_valid, m_rsp_v);
      end
      if (m_rsp_v != 0) begin
        total++;
        if (rsp_rdata !== 8'h5A) begin
          bad++; $display("FAIL midrst_rdata n=%0d: got %h want 5a", n, rsp_rdata);
        end
      end
      @(posedge clk);
      m_commit(acc);
      if (acc >= 0) t_v[acc] = 1'b0;
      #1;
    end
  endtask

  task automatic test_boundary();
    int acc;
    logic [WIDTH-1:0] want [5];
    want[2] = 8'hFF; want[4] = 8'h00;
    for (int n = 0; n < 5; n++) begin
      clear_reqs();
      if (n == 0) set_req(1, 1'b1, 7, 'hFF);
      if (n == 1) set_req(1, 1'b0, 7, 0);
      if (n == 3) set_req(0, 1'b0, 0, 0);
      apply();
      @(negedge clk);
      total++;
      if (rsp_valid !== m_rsp_v) begin
        bad++; $display("FAIL bound_rsp n=%0d: got %b want %b", n, rsp_valid, m_rsp_v);
      end
      if (n == 2 || n == 4) begin
        total++;
        if (rsp_rdata !== want[n]) begin
          bad++; $display("FAIL bound_rdata n=%0d: got %h want %h", n, rsp_rdata, want[n]);
        end
      end
      @(posedge clk);
      m_commit(acc);
      #1;
    end
  endtask

  task automatic test_random();
    int acc;
    logic [NREQ-1:0] eg;
    clear_reqs();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!t_v[i] && $urandom_range(1, 0) == 1) begin
          set_req(i, 1'($urandom_range(1, 0)), $urandom_range(DEPTH - 1, 0),
                  $urandom_range(255, 0));
        end
      end
      if (n == 299) clear_reqs();
      apply();
      @(negedge clk);
      eg = m_grant();
      total++;
      if (req_ready !== eg) begin
        bad++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, req_ready, eg);
      end
      total++;
      if (rsp_valid !== m_rsp_v) begin
        bad++; $display("FAIL rand_rsp_valid cyc %0d: got %b want %b", cyc, rsp_valid, m_rsp_v);
      end
      if (m_rsp_v != 0) begin
        total++;
        if (rsp_rdata !== m_rsp_d) begin
          bad++; $display("FAIL rand_rdata cyc %0d: got %h want %h", cyc, rsp_rdata, m_rsp_d);
        end
      end
      @(posedge clk);
      m_commit(acc);
      if (acc >= 0) t_v[acc] = 1'b0;
      #1;
    end
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_write_read();
    test_contention();
    test_fairness();
    test_reset_midflight();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
